ws2812_pixel_rx: RTL and testbench
==================================

// Module: ws2812_pixel_rx
// PURPOSE
//  Decodes a WS2812B-style single-wire LED stream back into 24-bit pixel words. It pairs with our
//  40 MHz stream generator: 24 bits per pixel, bit 0 first, and bit value encoded by high-pulse width.
//  It measures each high pulse, assembles pixels, flags frame ends (long low gap) and errors,
//  and re-drives bits after the first pixel on dout, like a chained LED. Used in test harnesses
//  and loopback checks.
// PARAMETERS
//  CNT_W        12    width of high/low cycle counters (saturating)
//  MIN_HIGH     4     high pulses shorter than this (cycles) are glitches; ignored
//  THRESH       25    high width >= THRESH -> bit 1, else bit 0 (TX: T0H=17, T1H=33 cycles)
//  MAX_HIGH     80    high width > MAX_HIGH -> error
//  RESET_CYCLES 1600  consecutive low cycles that end a frame (TX gap = 2001 cycles)
//  FORWARD      1     1 = forward bits after pixel 0 on dout; 0 = dout tied 0
// PORTS
//  clk          in   1   40 MHz clock
//  reset        in   1   asynchronous, active-low reset (0 = reset)
//  din          in   1   asynchronous serial stream
//  pixel        out  24  last completed pixel; bit n = n-th received bit
//  pixel_valid  out  1   1-cycle pulse when pixel updates
//  pixel_count  out  9   pixels completed in current/last frame, saturates at 511
//  frame_done   out  1   1-cycle pulse when frame gap detected
//  err          out  1   1-cycle pulse on over-long high or partial pixel at frame end
//  busy         out  1   state != IDLE
//  dout         out  1   forwarded stream
// BEHAVIOUR
//  - reset=0: all outputs, counters and sync flops cleared at once; state=IDLE.
//  - din passes through a 2-flop synchroniser (s1,s2) plus an edge flop s3. rise = s2&~s3,
//    fall = ~s2&s3. Every decision is registered on the edge after rise/fall is seen.
//    pixel_valid goes high exactly 3 clk edges after the first edge that samples din=0.
//  - FSM states IDLE, HIGH, LOW:
//    IDLE: leave only on rise -> HIGH; high_cnt=1; pixel_count cleared on this rise.
//          A line already high when reset releases is ignored until it falls and rises again.
//    HIGH: high_cnt++ (saturating). On fall -> LOW, low_cnt=1, then:
//          high_cnt<MIN_HIGH: discard, bit_idx unchanged;
//          high_cnt>MAX_HIGH: err pulse, partial pixel dropped, bit_idx=0;
//          else shreg[bit_idx]=(high_cnt>=THRESH). If bit_idx==23: pixel<=word,
//          pixel_valid pulse, pixel_count++ (sat 511), bit_idx=0, fwd<=FORWARD; else bit_idx++.
//    LOW:  low_cnt++ (saturating). On rise -> HIGH with high_cnt=1.
//          When low_cnt==RESET_CYCLES -> IDLE: frame_done pulse; if bit_idx!=0, err pulse in
//          the same cycle and the partial is discarded; bit_idx=0; fwd=0.
//  - dout = fwd & s2 (registered). fwd only changes while the line is low, so forwarded
//    pulses are never truncated; forwarded pulses equal input width, delayed 3 cycles.
//  - pixel and pixel_count hold between frames; pixel_count is readable after frame_done.
//  - A glitch never aborts a frame and never counts as a bit.
// TESTING
//  1 TX timing (T0H17/T0L35, T1H33/T1L19), 24'h00b000 bit0 first, 2001 low -> pixel=00b000,
//    one pixel_valid, frame_done, pixel_count=1, err=0, dout=0 throughout.
//  2 Pixels 00b000,00f060,00b0b0 back-to-back + gap -> 3 valid pulses in order, count=3,
//    dout carries exactly 48 high pulses of widths 17/33 matching pixels 2-3.
//  3 2-cycle high glitch inside the low of bit 5 of 00f060 -> ignored, pixel=00f060, err=0.
//  4 100-cycle high at bit 7 -> err pulse; next full pixel 0000b0 decoded correctly.
//  5 10 valid bits then 2001 low -> frame_done and err in the same cycle, no pixel_valid, count=0.
//  6 reset=0 after bit 12 -> outputs 0 immediately; after release, b00000 decodes from bit 0.

Source files
------------

// File: rtl/ws2812_pixel_rx_if.sv
// Signal bundle between the WS2812 pixel receiver and whatever drives/observes it.
// The slave side is the receiver; the master side drives din and watches the decode.
interface ws2812_pixel_rx_if;
  logic        din;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic [8:0]  pixel_count;
  logic        frame_done;
  logic        err;
  logic        busy;
  logic        dout;

  modport master (
    output din,
    input  pixel, pixel_valid, pixel_count, frame_done, err, busy, dout
  );

  modport slave (
    input  din,
    output pixel, pixel_valid, pixel_count, frame_done, err, busy, dout
  );
endinterface

// File: rtl/ws2812_pixel_rx.sv
// WS2812B-style single-wire stream decoder: measures high-pulse widths into 24-bit pixels,
// flags frame gaps and malformed pulses, and re-drives bits after pixel 0 on dout.
module ws2812_pixel_rx #(
  parameter int CNT_W        = 12,
  parameter int MIN_HIGH     = 4,
  parameter int THRESH       = 25,
  parameter int MAX_HIGH     = 80,
  parameter int RESET_CYCLES = 1600,
  parameter int FORWARD      = 1
) (
  input logic               clk,
  input logic               reset,
  ws2812_pixel_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] THR_C   = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] RST_C   = CNT_W'(RESET_CYCLES);
  localparam logic             FWD_EN  = (FORWARD != 0);

  state_t           state_q, state_d;
  logic             s1, s2, s3;
  logic [1:0]       sync_vld;
  logic             armed;
  logic             rise, fall;
  logic [CNT_W-1:0] high_q, high_d, low_q, low_d;
  logic [4:0]       idx_q, idx_d;
  logic [23:0]      shreg_q, shreg_d, word;
  logic [23:0]      pixel_q, pixel_d;
  logic [8:0]       count_q, count_d;
  logic             fwd_q, fwd_d;
  logic             pv_q, pv_d, fd_q, fd_d, err_q, err_d;
  logic             dout_q;

  // A line that is already high when reset releases must not look like a rise:
  // rises are only honoured once the synchronised line has been seen low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      sync_vld <= '0;
      armed    <= 1'b0;
    end else begin
      s1       <= bus.din;
      s2       <= s1;
      s3       <= s2;
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | (sync_vld[1] & ~s2);
    end
  end

  assign rise = s2 & ~s3 & armed;
  assign fall = ~s2 & s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      high_q  <= '0;
      low_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      pixel_q <= '0;
      count_q <= '0;
      fwd_q   <= 1'b0;
      pv_q    <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      pixel_q <= pixel_d;
      count_q <= count_d;
      fwd_q   <= fwd_d;
      pv_q    <= pv_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
      dout_q  <= fwd_q & s2;
    end
  end

  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pixel_d = pixel_q;
    count_d = count_q;
    fwd_d   = fwd_q;
    pv_d    = 1'b0;
    fd_d    = 1'b0;
    err_d   = 1'b0;
    word    = shreg_q;
    word[idx_q] = (high_q >= THR_C);

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          high_d  = CNT_W'(1);
          count_d = '0;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
          low_d   = CNT_W'(1);
          if (high_q >= MIN_C) begin
            if (high_q > MAX_C) begin
              err_d = 1'b1;
              idx_d = '0;
            end else begin
              shreg_d = word;
              if (idx_q == 5'd23) begin
                pixel_d = word;
                pv_d    = 1'b1;
                idx_d   = '0;
                fwd_d   = FWD_EN;
                if (count_q != '1) count_d = count_q + 1'b1;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
        end else if (high_q != '1) begin
          high_d = high_q + 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          high_d  = CNT_W'(1);
        end else if (low_q == RST_C) begin
          state_d = IDLE;
          fd_d    = 1'b1;
          err_d   = (idx_q != '0);
          idx_d   = '0;
          fwd_d   = 1'b0;
        end else if (low_q != '1) begin
          low_d = low_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pv_q;
  assign bus.pixel_count = count_q;
  assign bus.frame_done  = fd_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.dout        = dout_q;

endmodule

// File: tb/tb_ws2812_pixel_rx.sv
// Scoreboard bench for ws2812_pixel_rx: a pulse-level reference model queues expected
// events and forwarded pulse widths; a monitor pops and compares them as the DUT emits them.
module tb_ws2812_pixel_rx;

  localparam int MIN_HIGH     = 4;
  localparam int THRESH       = 25;
  localparam int MAX_HIGH     = 80;
  localparam int RESET_CYCLES = 1600;
  localparam int GAP          = 2001;

  typedef struct {
    bit          pv;
    bit          fd;
    bit          er;
    logic [23:0] px;
    int          cnt;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #12 clk = ~clk;

  ws2812_pixel_rx_if bus ();

  ws2812_pixel_rx #(
    .CNT_W(12), .MIN_HIGH(MIN_HIGH), .THRESH(THRESH), .MAX_HIGH(MAX_HIGH),
    .RESET_CYCLES(RESET_CYCLES), .FORWARD(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_dout = 0;
  int   dw = 0;
  ev_t  evq[$];
  int   doutq[$];
  bit   bitq[$];
  bit   m_active = 0;
  bit   m_fwd = 0;
  int   m_count = 0;
  ev_t  e;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call per high pulse (by width) and per low stretch (by length).
  task automatic model_pulse(int h);
    logic [23:0] w;
    if (!m_active) begin
      m_active = 1;
      m_count  = 0;
    end
    if (m_fwd) doutq.push_back(h);
    if (h >= MIN_HIGH) begin
      if (h > MAX_HIGH) begin
        evq.push_back('{pv:1'b0, fd:1'b0, er:1'b1, px:24'h0, cnt:m_count});
        bitq.delete();
      end else begin
        bitq.push_back(h >= THRESH);
        if (bitq.size() == 24) begin
          for (int i = 0; i < 24; i++) w[i] = bitq[i];
          m_count = (m_count < 511) ? m_count + 1 : 511;
          evq.push_back('{pv:1'b1, fd:1'b0, er:1'b0, px:w, cnt:m_count});
          bitq.delete();
          m_fwd = 1;
        end
      end
    end
  endtask

  task automatic model_low(int l);
    if (m_active && l >= RESET_CYCLES + 4) begin
      evq.push_back('{pv:1'b0, fd:1'b1, er:(bitq.size() != 0), px:24'h0, cnt:m_count});
      bitq.delete();
      m_fwd    = 0;
      m_active = 0;
    end
  endtask

  task automatic model_reset();
    bitq.delete();
    m_active = 0;
    m_fwd    = 0;
    m_count  = 0;
  endtask

  task automatic send_pulse(int h, int l);
    model_pulse(h);
    bus.din = 1'b1;
    repeat (h) @(negedge clk);
    model_low(l);
    bus.din = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bit(bit b, int last_low);
    send_pulse(b ? 33 : 17, (last_low != 0) ? last_low : (b ? 19 : 35));
  endtask

  task automatic send_pixel(logic [23:0] px, int gap);
    for (int i = 0; i < 24; i++) send_bit(px[i], (i == 23) ? gap : 0);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_pixel"}, bus.pixel, 0);
    check({tag, "_count"}, bus.pixel_count, 0);
    check({tag, "_flags"}, {bus.pixel_valid, bus.frame_done, bus.err, bus.busy, bus.dout}, 0);
  endtask

  task automatic drain(string tag);
    repeat (20) @(negedge clk);
    check({tag, "_events_left"}, evq.size(), 0);
    check({tag, "_dout_left"}, doutq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.pixel_valid || bus.frame_done || bus.err) begin
        if (evq.size() == 0) begin
          check("unexpected_event", {bus.pixel_valid, bus.frame_done, bus.err}, 0);
        end else begin
          e = evq.pop_front();
          check("event_kind", {bus.pixel_valid, bus.frame_done, bus.err}, {e.pv, e.fd, e.er});
          if (e.pv) check("pixel", bus.pixel, e.px);
          check("pixel_count", bus.pixel_count, e.cnt);
        end
      end
      if (bus.dout) begin
        dw++;
      end else if (dw != 0) begin
        n_dout++;
        if (doutq.size() == 0) check("dout_unexpected", dw, 0);
        else check("dout_width", dw, doutq.pop_front());
        dw = 0;
      end
    end
  end

  initial begin
    int d0, npx, mode, h, l, nb;
    logic [23:0] px;
    bus.din = 1'b0;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // 1: single pixel, nothing forwarded
    d0 = n_dout;
    send_pixel(24'h00b000, GAP);
    drain("t1");
    check("t1_dout_pulses", n_dout - d0, 0);

    // 2: three pixels, pixels 2-3 forwarded
    d0 = n_dout;
    send_pixel(24'h00b000, 0);
    send_pixel(24'h00f060, 0);
    send_pixel(24'h00b0b0, GAP);
    drain("t2");
    check("t2_dout_pulses", n_dout - d0, 48);

    // 3: short glitch inside the low of bit 5
    px = 24'h00f060;
    for (int i = 0; i < 24; i++) begin
      if (i == 5) begin
        send_pulse(px[i] ? 33 : 17, 10);
        send_pulse(2, px[i] ? 7 : 23);
      end else begin
        send_bit(px[i], (i == 23) ? GAP : 0);
      end
    end
    drain("t3");

    // 4: over-long high at bit 7, then a clean pixel
    px = 24'h0000b0;
    for (int i = 0; i < 7; i++) send_bit(px[i], 0);
    send_pulse(100, 35);
    send_pixel(px, GAP);
    drain("t4");

    // 5: partial pixel at frame end
    for (int i = 0; i < 10; i++) send_bit(i[0], (i == 9) ? GAP : 0);
    drain("t5");

    // 6: reset mid-pixel
    px = 24'hb00000;
    for (int i = 0; i < 13; i++) send_bit(px[i], 0);
    check("t6_busy", bus.busy, 1);
    reset = 1'b0;
    #1;
    check_zero("t6_reset");
    model_reset();
    check("t6_events_at_reset", evq.size(), 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    send_pixel(px, GAP);
    drain("t6");

    // 7: line already high when reset releases
    bus.din = 1'b1;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("t7_busy_high", bus.busy, 0);
    bus.din = 1'b0;
    repeat (30) @(negedge clk);
    send_pixel(24'h00f060, GAP);
    drain("t7");

    // 8: randomized frames with glitches, over-long pulses and truncated endings
    for (int f = 0; f < 6; f++) begin
      npx  = $urandom_range(1, 3);
      mode = $urandom_range(0, 5);
      for (int p = 0; p < npx; p++) begin
        for (int i = 0; i < 24; i++) begin
          bit b;
          b = 1'($urandom);
          h = b ? $urandom_range(28, 60) : $urandom_range(6, 22);
          l = $urandom_range(4, 24);
          if (p == npx - 1 && i == 23 && mode != 1) l = $urandom_range(1700, 1900);
          if (mode == 0 && p == 0 && i == 3) send_pulse($urandom_range(81, 150), 20);
          if (l < 100 && $urandom_range(0, 15) == 0) begin
            send_pulse(h, 4);
            send_pulse($urandom_range(1, 3), l);
          end else begin
            send_pulse(h, l);
          end
        end
      end
      if (mode == 1) begin
        nb = $urandom_range(1, 23);
        for (int i = 0; i < nb; i++)
          send_pulse($urandom_range(0, 1) ? 33 : 17, (i == nb - 1) ? GAP : 20);
      end
      drain("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
